// File: rtl/winograd_tile_buffer_if.sv
// Pixel-in / tile-out stream bundle for the Winograd tile buffer.
interface winograd_tile_buffer_if #(
    parameter int unsigned W = 8
);
    logic              i_valid;
    logic [W-1:0]      i_pixel;
    logic              o_ready;
    logic              o_valid;
    logic [16*W-1:0]   o_tile;
    logic              o_last;
    logic              i_tile_ready;

    // Buffer side: consumes pixels, produces tiles
    modport slave (
        input  i_valid,
        input  i_pixel,
        input  i_tile_ready,
        output o_ready,
        output o_valid,
        output o_tile,
        output o_last
    );

    // Environment side: produces pixels, consumes tiles
    modport master (
        output i_valid,
        output i_pixel,
        output i_tile_ready,
        input  o_ready,
        input  o_valid,
        input  o_tile,
        input  o_last
    );
endinterface

// File: rtl/winograd_tile_buffer.sv
// Winograd F(2x2,3x3) input tiler: turns a raster pixel stream into
// overlapping 4x4 tiles (stride 2), using three column-shifted line
// buffers plus a 3-column history of the current 4-row window.
module winograd_tile_buffer #(
    parameter int unsigned W     = 8,
    parameter int unsigned IMG_W = 6,
    parameter int unsigned IMG_H = 6
) (
    input  logic                   clk,
    input  logic                   rstn,
    winograd_tile_buffer_if.slave  bus
);
    localparam int unsigned CW = $clog2(IMG_W);
    localparam int unsigned RW = $clog2(IMG_H);
    localparam int unsigned TW = 16 * W;

    logic [CW-1:0] c_q, c_d;
    logic [RW-1:0] r_q, r_d;
    logic          o_valid_q, o_valid_d;
    logic          o_last_q, o_last_d;
    logic [TW-1:0] o_tile_q, o_tile_d;

    // lb[0] = row r-3, lb[1] = row r-2, lb[2] = row r-1 at the current column
    logic [2:0][IMG_W-1:0][W-1:0] lb_q, lb_d;
    // Previous three columns of the 4-row window: [row][col], col 2 newest
    logic [3:0][2:0][W-1:0]       win_q, win_d;
    logic [3:0][W-1:0]            col_new;
    logic [TW-1:0]                tile_c;

    logic accept, row_end, frame_end, emit;

    // Handshake and tile-completion decode
    always_comb begin
        accept    = bus.i_valid && bus.o_ready;
        row_end   = (c_q == CW'(IMG_W - 1));
        frame_end = row_end && (r_q == RW'(IMG_H - 1));
        emit      = accept && r_q[0] && (r_q >= RW'(3)) && c_q[0] && (c_q >= CW'(3));
    end

    // Incoming column (top to bottom) and the tile it would complete
    always_comb begin
        col_new[0] = lb_q[0][c_q];
        col_new[1] = lb_q[1][c_q];
        col_new[2] = lb_q[2][c_q];
        col_new[3] = bus.i_pixel;
        tile_c     = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 3; j++) begin
                tile_c[(4*i+j)*W +: W] = win_q[i][j];
            end
            tile_c[(4*i+3)*W +: W] = col_new[i];
        end
    end

    // Raster position of the next pixel
    always_comb begin
        c_d = c_q;
        r_d = r_q;
        if (accept) begin
            if (row_end) begin
                c_d = '0;
                r_d = frame_end ? '0 : r_q + RW'(1);
            end else begin
                c_d = c_q + CW'(1);
            end
        end
    end

    // Line buffers shift up one row per column; window slides one column
    always_comb begin
        lb_d  = lb_q;
        win_d = win_q;
        if (accept) begin
            lb_d[0][c_q] = lb_q[1][c_q];
            lb_d[1][c_q] = lb_q[2][c_q];
            lb_d[2][c_q] = bus.i_pixel;
            for (int i = 0; i < 4; i++) begin
                win_d[i][0] = win_q[i][1];
                win_d[i][1] = win_q[i][2];
                win_d[i][2] = col_new[i];
            end
        end
    end

    // Output tile register: load on completion, hold until taken
    always_comb begin
        o_valid_d = o_valid_q;
        o_last_d  = o_last_q;
        o_tile_d  = o_tile_q;
        if (emit) begin
            o_valid_d = 1'b1;
            o_last_d  = frame_end;
            o_tile_d  = tile_c;
        end else if (bus.i_tile_ready) begin
            o_valid_d = 1'b0;
            o_last_d  = 1'b0;
        end
    end

    // Control and output state with synchronous reset
    always_ff @(posedge clk) begin
        if (!rstn) begin
            c_q       <= '0;
            r_q       <= '0;
            o_valid_q <= 1'b0;
            o_last_q  <= 1'b0;
            o_tile_q  <= '0;
        end else begin
            c_q       <= c_d;
            r_q       <= r_d;
            o_valid_q <= o_valid_d;
            o_last_q  <= o_last_d;
            o_tile_q  <= o_tile_d;
        end
    end

    // Pixel storage; every location is rewritten before it reaches a tile
    always_ff @(posedge clk) begin
        lb_q  <= lb_d;
        win_q <= win_d;
    end

    assign bus.o_ready = !o_valid_q || bus.i_tile_ready;
    assign bus.o_valid = o_valid_q;
    assign bus.o_last  = o_last_q;
    assign bus.o_tile  = o_tile_q;

endmodule

// File: doc/winograd_tile_buffer.md
WINOGRAD_TILE_BUFFER -- requirements
Module: winograd_tile_buffer

Interface
REQ-001 Parameter W, default 8: pixel width in bits.
REQ-002 Parameter IMG_W, default 6: frame width in pixels; even, >= 4.
REQ-003 Parameter IMG_H, default 6: frame height in pixels; even, >= 4.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rstn  input  1  synchronous active-low reset, sampled on rising edge of clk.
REQ-006 i_valid  input  1  pixel stream valid.
REQ-007 i_pixel  input  W  pixel, raster order (row-major, row 0 first).
REQ-008 o_ready  output  1  block accepts i_pixel when i_valid && o_ready.
REQ-009 o_valid  output  1  o_tile holds a complete 4x4 tile.
REQ-010 o_tile  output  16*W  tile; element (i,j), i=row 0..3 top-down, j=col 0..3 left-right, at bits [(4*i+j)*W +: W].
REQ-011 o_last  output  1  qualifies o_valid; high on final tile of frame.
REQ-012 i_tile_ready  input  1  downstream (data transform stage) accepts tile when o_valid && i_tile_ready.

Function
REQ-013 Pixel accepted only on the cycle where i_valid && o_ready; otherwise no state change from input.
REQ-014 o_ready SHALL equal !o_valid || i_tile_ready (combinational).
REQ-015 Column counter c (0..IMG_W-1) and row counter r (0..IMG_H-1) track the position of the next pixel; c increments per accepted pixel, wraps to 0 with r increment at c=IMG_W-1.
REQ-016 After pixel (IMG_H-1, IMG_W-1) accepted, c and r return to 0; the next pixel starts a new frame with no idle cycle.
REQ-017 Block keeps the last three complete rows in line buffers (3 x IMG_W x W) plus a 4x4 sliding window of the current row; stores each accepted pixel.
REQ-018 Tile emitted when accepted pixel has r odd, r >= 3, c odd, c >= 3 (stride 2, overlap 2 — F(2x2,3x3) tiling).
REQ-019 Emitted tile covers rows r-3..r, cols c-3..c; element (3,3) equals the completing pixel.
REQ-020 o_valid, o_tile, o_last registered: valid the cycle after the completing pixel's handshake (latency 1).
REQ-021 o_valid held and o_tile/o_last stable until i_tile_ready sampled high; then o_valid drops unless a new tile completes the same cycle, in which case the new tile loads (back-to-back).
REQ-022 o_last high iff completing pixel is (IMG_H-1, IMG_W-1).
REQ-023 Tiles per frame = ((IMG_W-2)/2)*((IMG_H-2)/2); no tile spans two frames.
REQ-024 No arithmetic on pixel values; bits passed unchanged.

Reset
REQ-025 When rstn low at a clock edge: o_valid=0, o_last=0, o_tile=0, c=0, r=0.
REQ-026 Reset mid-frame discards the partial frame and any pending tile; next accepted pixel is (0,0).
REQ-027 Line buffer contents need not be cleared; every location is rewritten before use in a tile.
REQ-028 o_ready SHALL be 1 during and after reset (o_valid=0).

Verification
REQ-029 IMG_W=IMG_H=6, pixel = raster index, i_valid=1, i_tile_ready=1 -> 4 tiles, o_valid one cycle after pixels 21,23,33,35; o_last only with last tile.
REQ-030 Same stream: tile0 rows {0,1,2,3},{6..9},{12..15},{18..21}; tile1 {2..5},{8..11},{14..17},{20..23}; tile2 {12..15},{18..21},{24..27},{30..33}; tile3 {14..17},{20..23},{26..29},{32..35}.
REQ-031 i_tile_ready=0 when tile0 appears, held 5 cycles -> o_ready=0, o_tile stable with o_valid=1, no pixel lost; all 4 tiles still correct.
REQ-032 Random i_valid gaps (~50%) -> identical tile sequence and contents as REQ-030.
REQ-033 rstn low 1 cycle after pixel 25, then fresh frame -> o_valid=0 next cycle, no stale tile; new frame yields exactly 4 correct tiles.
REQ-034 Two frames back-to-back, second offset by +100 -> 8 tiles, o_last on tiles 4 and 8, frame-2 tile0 element (0,0)=100.
